// File: rtl/iir_biquad_seq.sv
// Direct-form-I biquad sequencer: issues one coefficient*sample product per tap to a
// start/ready MAC, then scales/saturates the sum. Define IIR_SEQ_ROUND_EN for round-half-up.
module iir_biquad_seq #(
  parameter int OPSIZE    = 8,
  parameter int COEF_FRAC = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [OPSIZE-1:0]   x_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [OPSIZE-1:0]   b0,
  input  logic signed [OPSIZE-1:0]   b1,
  input  logic signed [OPSIZE-1:0]   b2,
  input  logic signed [OPSIZE-1:0]   a1,
  input  logic signed [OPSIZE-1:0]   a2,
  output logic signed [OPSIZE-1:0]   y_out,
  output logic                       out_valid,
  output logic                       mac_start,
  output logic signed [OPSIZE-1:0]   mac_a,
  output logic signed [OPSIZE-1:0]   mac_b,
  output logic                       mac_clr,
  input  logic signed [2*OPSIZE-1:0] mac_out,
  input  logic                       mac_ready
);

  localparam int AW = 2*OPSIZE + 1;
  localparam logic signed [AW-1:0]     YMAX = AW'((1 << (OPSIZE-1)) - 1);
  localparam logic signed [AW-1:0]     YMIN = AW'(-(1 << (OPSIZE-1)));
  localparam logic signed [OPSIZE-1:0] SMAX = YMAX[OPSIZE-1:0];
  localparam logic signed [OPSIZE-1:0] SMIN = YMIN[OPSIZE-1:0];
`ifdef IIR_SEQ_ROUND_EN
  localparam logic signed [AW-1:0]     HALF = AW'(1 << (COEF_FRAC-1));
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_OUTPUT
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               tap_q, tap_d;
  logic signed [OPSIZE-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [OPSIZE-1:0] y1_q, y1_d, y2_q, y2_d;
  logic signed [OPSIZE-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic signed [OPSIZE-1:0] a1_q, a1_d, a2_q, a2_d;
  logic signed [OPSIZE-1:0] y_q, y_d, ma_q, ma_d, mb_q, mb_d;
  logic                     ov_q, ov_d;

  logic [2:0]               nxt_tap;
  logic signed [OPSIZE-1:0] op_a, op_b;
  logic signed [AW-1:0]     acc_ext, acc_sh;
  logic signed [OPSIZE-1:0] y_sat;

  function automatic logic signed [OPSIZE-1:0] sat_neg(input logic signed [OPSIZE-1:0] v);
    return (v == SMIN) ? SMAX : -v;
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign mac_clr   = !reset || (state_q == S_CLEAR);
  assign y_out     = y_q;
  assign out_valid = ov_q;
  assign mac_a     = ma_q;
  assign mac_b     = mb_q;

  // Operands are loaded on the edge that enters ISSUE, so they are stable for the whole tap.
  always_comb begin
    nxt_tap = (state_q == S_WAIT_HI) ? 3'(tap_q + 3'd1) : 3'd0;
    op_a    = b0_q;
    op_b    = x_q;
    case (nxt_tap)
      3'd0:    begin op_a = b0_q;          op_b = x_q;  end
      3'd1:    begin op_a = b1_q;          op_b = x1_q; end
      3'd2:    begin op_a = b2_q;          op_b = x2_q; end
      3'd3:    begin op_a = sat_neg(a1_q); op_b = y1_q; end
      default: begin op_a = sat_neg(a2_q); op_b = y2_q; end
    endcase
  end

  always_comb begin
    acc_ext = {mac_out[2*OPSIZE-1], mac_out};
`ifdef IIR_SEQ_ROUND_EN
    acc_ext = acc_ext + HALF;
`endif
    acc_sh = acc_ext >>> COEF_FRAC;
    if (acc_sh > YMAX)      y_sat = SMAX;
    else if (acc_sh < YMIN) y_sat = SMIN;
    else                    y_sat = acc_sh[OPSIZE-1:0];
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    x_d       = x_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    y_d       = y_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    ov_d      = 1'b0;
    mac_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          b0_d    = b0;
          b1_d    = b1;
          b2_d    = b2;
          a1_d    = a1;
          a2_d    = a2;
          tap_d   = 3'd0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ma_d    = op_a;
        mb_d    = op_b;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (mac_ready) begin
          mac_start = 1'b1;
          state_d   = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!mac_ready) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (mac_ready) begin
          if (tap_q < 3'd4) begin
            tap_d   = nxt_tap;
            ma_d    = op_a;
            mb_d    = op_b;
            state_d = S_ISSUE;
          end else begin
            state_d = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        y_d     = y_sat;
        ov_d    = 1'b1;
        x2_d    = x1_q;
        x1_d    = x_q;
        y2_d    = y1_q;
        y1_d    = y_sat;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      x_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      y_q     <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      x_q     <= x_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      y_q     <= y_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Scoreboard bench for iir_biquad_seq with a behavioural start/ready MAC.
module tb_iir_biquad_seq;
  localparam int MAC_LAT = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [7:0]  x_in, b0, b1, b2, a1, a2;
  logic               in_valid, in_ready;
  logic signed [7:0]  y_out, mac_a, mac_b;
  logic               out_valid, mac_start, mac_clr, mac_ready;
  logic signed [15:0] mac_out;

  always #5 clk = ~clk;

  iir_biquad_seq #(.OPSIZE(8), .COEF_FRAC(6)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .y_out(y_out), .out_valid(out_valid), .mac_start(mac_start),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr),
    .mac_out(mac_out), .mac_ready(mac_ready)
  );

  // Behavioural MAC: mac_clr is its reset; busy MAC_LAT cycles per product.
  logic signed [7:0] ma, mb;
  int                mcnt;
  always @(posedge clk) begin
    if (mac_clr) begin
      mac_out <= '0; mac_ready <= 1'b1; mcnt <= 0; ma <= '0; mb <= '0;
    end else if (mcnt != 0) begin
      if (mcnt == 1) begin
        mac_out   <= mac_out + ma * mb;
        mac_ready <= 1'b1;
      end
      mcnt <= mcnt - 1;
    end else if (mac_start && mac_ready) begin
      ma <= mac_a; mb <= mac_b; mac_ready <= 1'b0; mcnt <= MAC_LAT;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  typedef struct { int y; int op3; } exp_t;
  exp_t expq[$];

  // Monitor: per-result handshake counts and output value.
  int   starts = 0, clrs = 0, op3 = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      starts = 0; clrs = 0;
    end else begin
      if (mac_clr) clrs++;
      if (mac_start) begin
        if (starts == 0) chk("clr_before_start", clrs, 1);
        if (starts == 3) op3 = mac_a;
        starts++;
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", y_out, 9999);
        end else begin
          e = expq.pop_front();
          chk("y_out", y_out, e.y);
          chk("start_count", starts, 5);
          chk("clr_count", clrs, 1);
          chk("tap3_operand", op3, e.op3);
        end
        starts = 0; clrs = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic send(input int x, input int c0, input int c1, input int c2,
                      input int ca1, input int ca2, input bit push,
                      input int ey, input int eop3);
    int n = 0;
    exp_t ne;
    if (push) begin
      ne.y = ey; ne.op3 = eop3;
      expq.push_back(ne);
    end
    @(posedge clk); #1;
    while (!in_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    x_in = 8'(x); b0 = 8'(c0); b1 = 8'(c1); b2 = 8'(c2); a1 = 8'(ca1); a2 = 8'(ca2);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    if (expq.size() != 0) begin
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    repeat (4) @(posedge clk);
  endtask

`ifdef IIR_SEQ_ROUND_EN
  localparam int NS_Y = 20;  // (1270+32)>>>6
`else
  localparam int NS_Y = 19;  // 1270>>>6
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s;
    reset = 1'b0; in_valid = 1'b0; x_in = '0;
    b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_y_out", y_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mac_start", mac_start, 0);
    chk("rst_mac_clr", mac_clr, 1);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // pass-through
    send(48, 64, 0, 0, 0, 0, 1, 48, 0);
    drain();

    // unit delay
    do_reset();
    send(10, 0, 64, 0, 0, 0, 1, 0, 0);
    send(20, 0, 64, 0, 0, 0, 1, 10, 0);
    drain();

    // feedback decay
    do_reset();
    send(64, 64, 0, 0, -32, 0, 1, 64, 32);
    send(0,  64, 0, 0, -32, 0, 1, 32, 32);
    send(0,  64, 0, 0, -32, 0, 1, 16, 32);
    drain();

    // output saturation both ways
    do_reset();
    send(127,  127, 0, 0, 0, 0, 1,  127, 0);
    send(-128, 127, 0, 0, 0, 0, 1, -128, 0);
    drain();

    // negation saturation: -(-128) issued as 127 against y1=10
    do_reset();
    send(10, 64, 0, 0, 0, 0, 1, 10, 0);
    send(0, 0, 0, 0, -128, 0, 1, NS_Y, 127);
    drain();

    // busy ignore
    do_reset();
    send(48, 64, 0, 0, 0, 0, 1, 48, 0);
    n = 0;
    while (mac_ready && n < 2000) begin @(posedge clk); #1; n++; end
    chk("busy_reach_wait", mac_ready, 0);
    @(posedge clk); #1;
    chk("busy_in_ready", in_ready, 0);
    x_in = 8'sd99; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("busy_in_ready_hold", in_ready, 0);
    drain();

    // reset in WAIT_HI of the third tap
    do_reset();
    send(30, 64, 0, 0, 0, 0, 1, 30, 0);
    drain();
    send(40, 64, 64, 0, -32, 0, 0, 0, 0);
    s = 0; n = 0;
    while (s < 3 && n < 2000) begin
      if (mac_start) s++;
      if (s < 3) begin @(posedge clk); #1; end
      n++;
    end
    chk("abort_third_start", s, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_mac_clr", mac_clr, 1);
    chk("abort_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("abort_mac_clr_hold", mac_clr, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    // cleared history leaves only b0*x
    send(48, 64, 64, 0, -32, 0, 1, 48, 32);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iir_biquad_seq.md
Name: iir_biquad_seq

Overview:
- Initiator/sequencer for the mac block's start/ready product-accumulate interface.
- Takes one signed sample per transaction and runs a direct-form-I biquad over five taps, issuing one product per tap to the mac.
- Scales and saturates the accumulated result, emits it, then updates the sample and output history.
- Sits between the sample stream and the mac instance of the IIR filter datapath.

Parameters:
- OPSIZE, 8, signed width of samples, coefficients and mac operands; the mac accumulator is 2*OPSIZE.
- COEF_FRAC, 6, fractional bits of coefficients (Q1.COEF_FRAC), so 1.0 = 64 at the default.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- x_in  in  OPSIZE  signed input sample.
- in_valid  in  1  sample offered; accepted only when in_ready=1.
- in_ready  out  1  high only in IDLE.
- b0, b1, b2  in  OPSIZE each  signed feed-forward coefficients; sampled at accept.
- a1, a2  in  OPSIZE each  signed feedback coefficients; sampled at accept.
- y_out  out  OPSIZE  signed filter output; holds between results.
- out_valid  out  1  one-cycle pulse when y_out is updated.
- mac_start  out  1  one-cycle start pulse to the mac.
- mac_a, mac_b  out  OPSIZE each  mac operands (coefficient, sample).
- mac_clr  out  1  active-high accumulator clear, wired to the mac's reset.
- mac_out  in  2*OPSIZE  mac accumulator.
- mac_ready  in  1  mac idle/done.

Behaviour:
- Transfer function: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2].
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - x1, x2, y1, y2, y_out, mac_a, mac_b = 0; out_valid = 0; mac_start = 0.
  - mac_clr = 1 (held for every cycle reset is low); in_ready = 1 in the cycle after reset is released.
- Reset mid-operation aborts the current sample: no out_valid and no history update.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch x_in and the five coefficients, set tap=0, go to CLEAR.
  - CLEAR: mac_clr=1 for exactly one cycle, go to ISSUE.
  - ISSUE: drive mac_a/mac_b for the current tap. If mac_ready=1, pulse mac_start for one cycle and go to WAIT_LO; otherwise stay. Operands are held stable from ISSUE until WAIT_HI exits.
  - WAIT_LO: stay until mac_ready=0, then go to WAIT_HI.
  - WAIT_HI: stay until mac_ready=1 (mac_out is now updated). If tap<4, increment tap and go to ISSUE; else go to OUTPUT.
  - OUTPUT: compute y, register y_out, pulse out_valid, shift history, go to IDLE.
- Tap order and operands (tap: mac_a, mac_b):
  - 0: b0, x
  - 1: b1, x1
  - 2: b2, x2
  - 3: neg(a1), y1
  - 4: neg(a2), y2
- neg(v) is saturating negation: -(-2^(OPSIZE-1)) = 2^(OPSIZE-1)-1.
- Output arithmetic: y = sat_OPSIZE(mac_out >>> COEF_FRAC), arithmetic shift. Saturation clamps to [-2^(OPSIZE-1), 2^(OPSIZE-1)-1].
- History update at OUTPUT: x2<=x1, x1<=x, y2<=y1, y1<=y, using the saturated value.
- in_valid outside IDLE is ignored; the sample is not queued.
- Minimum latency from accept to out_valid is 2 + 5*(mac cycle + 1) + 1 cycles. The exact value is set by the mac, so the bench checks handshake order, not fixed cycle counts.

Optional Feature:
- Macro: IIR_SEQ_ROUND_EN.
- Defined: OUTPUT adds 2^(COEF_FRAC-1) to mac_out in 2*OPSIZE+1 bits before the shift (round half up), then saturates.
- Undefined: plain truncation via arithmetic shift (round toward -inf).

Test Plan:
- Pass-through: b0=64, others 0; x=48 -> single out_valid, y_out=48, mac_start pulsed exactly 5 times, one mac_clr pulse before the first start.
- Unit delay: b1=64, others 0; x=10 then x=20 -> y_out=0 then 10.
- Feedback decay: b0=64, a1=-32, others 0; x=64, 0, 0 -> y_out=64, 32, 16. Round-mode build gives the same values.
- Saturation: b0=127, x=127 (16129>>>6=252) -> y_out=127; b0=127, x=-128 -> y_out=-128. Neg-saturate: a1=-128, y1=10 -> operand 127 is issued.
- Busy ignore: pulse in_valid with x=99 during WAIT_HI -> no accept, in_ready stays 0, result matches the first sample only.
- Reset mid-operation: drive reset=0 in WAIT_HI during the third tap -> no out_valid; history cleared; mac_clr=1 while reset is low; in_ready=1 the cycle after release. The next x=48 with b0=64 gives y_out=48.
